// File: rtl/regfile_pkg.sv
// Shared constants, read-source encoding and packed-port helpers for the
// multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned ZERO_ADDR  = 0;

    typedef enum logic [1:0] {
        SRC_ARRAY,
        SRC_WR0,
        SRC_WR1,
        SRC_ZERO
    } rdSrc_e;

    // LSB offset of port idx inside a packed bus of width-bit fields.
    function automatic int unsigned sliceLsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins ties.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     any_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;

    // Clear is evaluated before set so a same-cycle re-issue keeps the bit high.
    always_comb begin
        busyNext = busy;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if ((wr0_en && wr0_addr == ADDR_W'(r)) || (wr1_en && wr1_addr == ADDR_W'(r)))
                busyNext[r] = 1'b0;
            if (iss_en && iss_addr == ADDR_W'(r))
                busyNext[r] = 1'b1;
        end
        if (ZERO_REG != 0)
            busyNext[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busyNext;
    end

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : gBusyPort
            localparam int unsigned ALSB = sliceLsb(i, ADDR_W);
            assign rd_busy[i] = busy[rd_addr[ALSB +: ADDR_W]];
        end
    endgenerate

    assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational reads with same-cycle write bypass,
// two rising-edge write ports, optional hardwired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     any_busy
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic        ZERO_ON  = (ZERO_REG != 0);
    localparam logic        BYPASS_ON = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];

    logic wr0Ok;
    logic wr1Ok;
    logic wr0Keep;

    assign wr0Ok   = wr0_en && !(ZERO_ON && wr0_addr == ADDR_W'(ZERO_ADDR));
    assign wr1Ok   = wr1_en && !(ZERO_ON && wr1_addr == ADDR_W'(ZERO_ADDR));
    // Port 1 (load writeback) wins a same-address collision.
    assign wr0Keep = wr0Ok && !(wr1Ok && wr1_addr == wr0_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++)
                regs[r] <= '0;
        end else begin
            if (wr0Keep)
                regs[wr0_addr] <= wr0_data;
            if (wr1Ok)
                regs[wr1_addr] <= wr1_data;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : gReadPort
            localparam int unsigned ALSB = sliceLsb(i, ADDR_W);
            localparam int unsigned DLSB = sliceLsb(i, DATA_W);

            logic [ADDR_W-1:0] addr;
            rdSrc_e            src;
            logic [DATA_W-1:0] data;

            assign addr = rd_addr[ALSB +: ADDR_W];

            // Outputs are forced to zero while reset is held, including bypass.
            always_comb begin
                src = SRC_ARRAY;
                if (!rst_n || (ZERO_ON && addr == ADDR_W'(ZERO_ADDR)))
                    src = SRC_ZERO;
                else if (BYPASS_ON && wr1Ok && wr1_addr == addr)
                    src = SRC_WR1;
                else if (BYPASS_ON && wr0Ok && wr0_addr == addr)
                    src = SRC_WR0;
            end

            always_comb begin
                data = '0;
                case (src)
                    SRC_ARRAY: data = regs[addr];
                    SRC_WR0:   data = wr0_data;
                    SRC_WR1:   data = wr1_data;
                    default:   data = '0;
                endcase
            end

            assign rd_data[DLSB +: DATA_W] = data;
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values queued at drive time,
// popped and compared when outputs are sampled.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr0_en;
    logic [AW-1:0]     wr0_addr;
    logic [DW-1:0]     wr0_data;
    logic              wr1_en;
    logic [AW-1:0]     wr1_addr;
    logic [DW-1:0]     wr1_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              any_busy;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expectVal(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        expQ.push_back(e);
    endtask

    task automatic checkVal(input logic [63:0] obs);
        exp_t e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow observed=%h", obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Expected {port1,port0} data, per-port busy bits and any_busy.
    task automatic checkAll(input string tag, input logic [63:0] data,
                            input logic [1:0] busy, input logic any);
        expectVal({tag, "_data"}, data);
        expectVal({tag, "_busy"}, {62'b0, busy});
        expectVal({tag, "_any"},  {63'b0, any});
        checkVal(rd_data);
        checkVal({62'b0, rd_busy});
        checkVal({63'b0, any_busy});
    endtask

    task automatic setRd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        #3;
        checkAll("in_reset", 64'h0, 2'b00, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            setRd(AW'(a), AW'(31 - a));
            #1;
            checkAll("reset_sweep", 64'h0, 2'b00, 1'b0);
        end

        // Same-cycle bypass on wr0, then array readback
        tick();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        setRd(5'd5, 5'd0);
        #1;
        checkAll("byp_wr0", {32'h0, 32'hDEADBEEF}, 2'b00, 1'b0);
        tick();
        idle();
        #1;
        checkAll("arr_r5", {32'h0, 32'hDEADBEEF}, 2'b00, 1'b0);

        // Both write ports on r7: wr1 forwarded and stored
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
        setRd(5'd7, 5'd5);
        #1;
        checkAll("byp_dual", {32'hDEADBEEF, 32'h22222222}, 2'b00, 1'b0);
        tick();
        idle();
        #1;
        checkAll("arr_r7", {32'hDEADBEEF, 32'h22222222}, 2'b00, 1'b0);

        // r0 ignores writes and issues
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        setRd(5'd0, 5'd0);
        #1;
        checkAll("r0_byp", 64'h0, 2'b00, 1'b0);
        tick();
        idle();
        #1;
        checkAll("r0_after", 64'h0, 2'b00, 1'b0);

        // Scoreboard on r9
        iss_en = 1'b1; iss_addr = 5'd9;
        setRd(5'd9, 5'd9);
        #1;
        checkAll("iss9_pre", 64'h0, 2'b00, 1'b0);
        tick();
        idle();
        #1;
        checkAll("iss9_post", 64'h0, 2'b11, 1'b1);
        iss_en = 1'b1; iss_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h12345678;
        #1;
        checkAll("iss_wb_pre", {32'h12345678, 32'h12345678}, 2'b11, 1'b1);
        tick();
        idle();
        #1;
        checkAll("iss_wb_post", {32'h12345678, 32'h12345678}, 2'b11, 1'b1);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hCAFEF00D;
        #1;
        checkAll("wb9_pre", {32'hCAFEF00D, 32'hCAFEF00D}, 2'b11, 1'b1);
        tick();
        idle();
        #1;
        checkAll("wb9_post", {32'hCAFEF00D, 32'hCAFEF00D}, 2'b00, 1'b0);

        // Mid-cycle reset clears contents and busy
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA5A5A5A5;
        tick();
        idle();
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        setRd(5'd3, 5'd4);
        #1;
        checkAll("pre_rst", {32'h0, 32'hA5A5A5A5}, 2'b10, 1'b1);
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h77777777;
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("rst_mid", 64'h0, 2'b00, 1'b0);
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkAll("post_rst", 64'h0, 2'b00, 1'b0);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0BADCAFE;
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        #1;
        checkAll("first_edge", {32'h0, 32'h0BADCAFE}, 2'b10, 1'b1);

        if (expQ.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read MIPS register file.
- Sits in the decode/writeback stages of the pipelined core. NUM_RD combinational read ports, two synchronous write ports (ALU and load writeback).
- Adds hardwired zero register, same-cycle write-to-read bypass, async reset, and a per-register busy scoreboard for hazard detection.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and issues.
- BYPASS, 1, when 1, read ports forward same-cycle write data.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr.
- rd_busy  out  NUM_RD  scoreboard busy bit of each read address.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback).
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- iss_en  in  1  issue: mark destination busy.
- iss_addr  in  ADDR_W  destination register of issued instruction.
- any_busy  out  1  OR of all busy bits (drain indicator).

Behaviour:
- Reset (rst_n low, async): all registers = 0, all busy bits = 0. While asserted: rd_data = 0, rd_busy = 0, any_busy = 0. Writes and issues are ignored.
- Reads: combinational from array, zero latency.
- Writes: occur at rising clk. This is a change from the former negedge write. Bypass covers the same-cycle read.
- Bypass (BYPASS=1): if wrN_en and wrN_addr == rd_addr[i] (and the address is not r0 when ZERO_REG=1), rd_data[i] = wrN_data.
  - If both write ports match the same read address, wr1_data is forwarded.
- BYPASS=0: reads return the pre-edge array value.
- Both write ports to the same address in one cycle: wr1 wins; the wr0 write is dropped.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - rd_data for address 0 is always 0, with no bypass.
  - Busy bit 0 is never set.
- Scoreboard, per-register busy bit, updated at rising clk:
  - Set when iss_en and iss_addr match.
  - Cleared when wr0_en or wr1_en writes that address.
  - Simultaneous issue and writeback to the same address: busy stays 1 (the new producer wins).
  - rd_busy[i] reflects registered busy state only. It is not bypass-cleared, so a register being written this cycle still shows busy until the next edge.
  - Re-issue of an already-busy register: stays 1, no error.
- Width rules: no arithmetic; addresses are full range, no out-of-range case.
- Reset mid-operation: pending busy bits and all register contents are lost immediately. The first edge after deassert behaves normally.

Decomposition:
- Shared package regfile_pkg: default DATA_W/ADDR_W constants, ZERO_ADDR constant, packed-port slice helper function.
- One natural sub-module: regfile_scoreboard (busy vector, set/clear/priority logic, any_busy). The data array and bypass mux stay in regfile_mp.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data = 0x00000000, rd_busy = 0, any_busy = 0.
- wr0 writes 0xDEADBEEF to r5 while rd_addr[0] = 5 in the same cycle -> rd_data[0] = 0xDEADBEEF before the edge (BYPASS=1). Next cycle it is read from the array as 0xDEADBEEF.
- wr0 (r7, 0x11111111) and wr1 (r7, 0x22222222) in the same cycle -> forwarded 0x22222222 and stored 0x22222222.
- Write 0xFFFFFFFF to r0 and issue r0 -> rd_data for r0 = 0, busy[0] = 0.
- Issue r9 -> rd_busy = 1 next cycle, any_busy = 1. Later, issue r9 together with a wr1 write to r9 -> rd_busy stays 1. A plain writeback to r9 -> rd_busy = 0.
- Write r3 = 0xA5A5A5A5, issue r4, pulse rst_n low mid-cycle -> outputs immediately 0. After release, r3 = 0 and busy[4] = 0.
